// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared types for the LED fader stage that sits behind blinky.
//   led_fader_state_e : 2-bit FSM state of the fader
//   is_ramp()         : true for the two states in which brightness moves
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } led_fader_state_e;

    function automatic logic is_ramp(input led_fader_state_e s);
        return (s == RAMP_UP) || (s == RAMP_DOWN);
    endfunction

endpackage

// File: rtl/led_fader_if.sv
// ---------------------------------------------------------------------------
// led_fader_if
// Bundles the LED request coming from blinky with the fader's outputs.
//   led_i   : binary LED request (high = on)
//   led_o   : PWM drive to the LED pin
//   level_o : current brightness, 0 .. 2**PwmBits-1
//   busy_o  : high while brightness is ramping
// master = the side producing led_i (blinky / testbench)
// slave  = the fader itself
// ---------------------------------------------------------------------------
interface led_fader_if #(
    parameter int PwmBits = 8
);
    logic               led_i;
    logic               led_o;
    logic [PwmBits-1:0] level_o;
    logic               busy_o;

    modport master (
        output led_i,
        input  led_o,
        input  level_o,
        input  busy_o
    );

    modport slave (
        input  led_i,
        output led_o,
        output level_o,
        output busy_o
    );
endinterface

// File: rtl/pwm_generator.sv
// ---------------------------------------------------------------------------
// pwm_generator
// Free-running PWM counter plus compare against the requested level.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   level_i : brightness, 0 .. 2**PwmBits-1
//   pwm_o   : registered PWM output, high level_i cycles out of every
//             2**PwmBits-1 cycles
// ---------------------------------------------------------------------------
module pwm_generator #(
    parameter int PwmBits = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [PwmBits-1:0] level_i,
    output logic               pwm_o
);

    localparam logic [PwmBits-1:0] MaxLevel = {PwmBits{1'b1}};
    localparam logic [PwmBits-1:0] CntLast  = MaxLevel - 1'b1;

    logic [PwmBits-1:0] cnt_q;

    // The counter runs 0..MaxLevel-1 so the period is MaxLevel cycles:
    // level 0 never fires and level MaxLevel is high on every cycle.
    // With PwmBits=1 the counter is stuck at 0 and pwm_o follows the level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            pwm_o <= 1'b0;
        end else begin
            pwm_o <= (cnt_q < level_i);
            if (cnt_q == CntLast) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_fader.sv
// ---------------------------------------------------------------------------
// led_fader
// Turns blinky's hard on/off LED request into a linear brightness ramp
// driven out as PWM. Same clock domain as blinky, no input synchronizer.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : led_fader_if slave (led_i in; led_o, level_o, busy_o out)
// Parameters:
//   PwmBits       : brightness / PWM width (1..16)
//   CyclesPerStep : clock cycles per one-level brightness step (>= 1)
// ---------------------------------------------------------------------------
module led_fader
    import led_pkg::*;
#(
    parameter int PwmBits       = 8,
    parameter int CyclesPerStep = 4
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    led_fader_if.slave bus
);

    localparam logic [PwmBits-1:0]  MaxLevel = {PwmBits{1'b1}};
    localparam int                  StepBits = (CyclesPerStep > 1) ? $clog2(CyclesPerStep) : 1;
    localparam logic [StepBits-1:0] StepLast = StepBits'(CyclesPerStep - 1);

    led_fader_state_e    state_q;
    logic [PwmBits-1:0]  level_q;
    logic [StepBits-1:0] step_q;
    logic                busy_q;
    logic                pwm;

    logic                step_tick;
    logic [PwmBits-1:0]  level_up;
    logic [PwmBits-1:0]  level_dn;

    // A reversal can leave RAMP_UP at MaxLevel or RAMP_DOWN at 0, so the
    // next-level values saturate instead of wrapping.
    assign step_tick = (step_q == StepLast);
    assign level_up  = (level_q == MaxLevel) ? MaxLevel : level_q + 1'b1;
    assign level_dn  = (level_q == '0)       ? '0       : level_q - 1'b1;

    // FSM, step counter and level register. The step counter restarts on
    // every state change so each ramp begins with a full step period, and
    // a direction change holds the level for that edge even if a tick lands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= OFF;
            level_q <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    if (bus.led_i) begin
                        state_q <= RAMP_UP;
                        busy_q  <= is_ramp(RAMP_UP);
                        step_q  <= '0;
                    end
                end
                RAMP_UP: begin
                    if (!bus.led_i) begin
                        state_q <= RAMP_DOWN;
                        busy_q  <= is_ramp(RAMP_DOWN);
                        step_q  <= '0;
                    end else if (step_tick) begin
                        step_q  <= '0;
                        level_q <= level_up;
                        if (level_up == MaxLevel) begin
                            state_q <= ON;
                            busy_q  <= is_ramp(ON);
                        end
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                ON: begin
                    if (!bus.led_i) begin
                        state_q <= RAMP_DOWN;
                        busy_q  <= is_ramp(RAMP_DOWN);
                        step_q  <= '0;
                    end
                end
                RAMP_DOWN: begin
                    if (bus.led_i) begin
                        state_q <= RAMP_UP;
                        busy_q  <= is_ramp(RAMP_UP);
                        step_q  <= '0;
                    end else if (step_tick) begin
                        step_q  <= '0;
                        level_q <= level_dn;
                        if (level_dn == '0) begin
                            state_q <= OFF;
                            busy_q  <= is_ramp(OFF);
                        end
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= OFF;
                    level_q <= '0;
                    step_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    pwm_generator #(
        .PwmBits(PwmBits)
    ) u_pwm (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .level_i(level_q),
        .pwm_o  (pwm)
    );

    assign bus.led_o   = pwm;
    assign bus.level_o = level_q;
    assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// ---------------------------------------------------------------------------
// tb_led_fader
// Directed bench for led_fader with PwmBits=4 (MaxLevel 15), CyclesPerStep=2,
// plus a slow second instance used to hold a level long enough to measure
// PWM duty. Expected values are queued per clock edge by the stimulus and
// checked by a separate monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_led_fader;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   edgeCnt = 0;
    int   errors  = 0;
    int   checks  = 0;

    typedef struct {
        int         edgeNum;
        logic [3:0] level;
        logic       busy;
        logic       led;
        bit         chkLed;
    } exp_t;

    exp_t expQ[$];
    exp_t monEntry;

    led_fader_if #(.PwmBits(4)) bus ();
    led_fader_if #(.PwmBits(4)) bus2 ();

    led_fader #(
        .PwmBits      (4),
        .CyclesPerStep(2)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    led_fader #(
        .PwmBits      (4),
        .CyclesPerStep(64)
    ) dut_slow (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    // Bench-side edge index; expectations are keyed to it.
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic checkNow(input string tag, input int lvl, input int busy, input int led);
        checkOutput({tag, "_level"}, int'(bus.level_o), lvl);
        checkOutput({tag, "_busy"},  int'(bus.busy_o),  busy);
        checkOutput({tag, "_led"},   int'(bus.led_o),   led);
    endtask

    task automatic pushExp(input int e, input int lvl, input bit busy, input bit led, input bit chkLed);
        exp_t x;
        x.edgeNum = e;
        x.level   = 4'(lvl);
        x.busy    = busy;
        x.led     = led;
        x.chkLed  = chkLed;
        expQ.push_back(x);
    endtask

    // Waits for the next edge, then changes led_i; the value is sampled
    // by the DUT on the edge after that, returned as sampleEdge.
    task automatic applyStimulus(input logic v, output int sampleEdge);
        @(posedge clk);
        #1;
        bus.led_i  = v;
        sampleEdge = edgeCnt + 1;
    endtask

    task automatic waitUntilEdge(input int n);
        while (edgeCnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: pops every expectation due at the current edge.
    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].edgeNum <= edgeCnt) begin
            monEntry = expQ.pop_front();
            if (monEntry.edgeNum < edgeCnt) begin
                checkOutput("late_entry", edgeCnt, monEntry.edgeNum);
            end else begin
                checkOutput($sformatf("e%0d_level", edgeCnt), int'(bus.level_o), int'(monEntry.level));
                checkOutput($sformatf("e%0d_busy", edgeCnt),  int'(bus.busy_o),  int'(monEntry.busy));
                if (monEntry.chkLed)
                    checkOutput($sformatf("e%0d_led", edgeCnt), int'(bus.led_o), int'(monEntry.led));
            end
        end
    end

    initial begin
        int e0;
        int r;
        int highs;
        int guard;

        bus.led_i  = 1'b0;
        bus2.led_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkNow("reset", 0, 0, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Idle: nothing moves with led_i low.
        @(posedge clk);
        #1;
        e0 = edgeCnt;
        for (int k = 1; k <= 50; k++) pushExp(e0 + k, 0, 1'b0, 1'b0, 1'b1);
        waitUntilEdge(e0 + 51);

        // Full ramp up: level k at e0+2k, ON at e0+30.
        $display("[TB] ramp up");
        applyStimulus(1'b1, e0);
        pushExp(e0, 0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            pushExp(e0 + 2*k - 1, k - 1, 1'b1, 1'b0, 1'b0);
            pushExp(e0 + 2*k, k, (k < 15), 1'b0, 1'b0);
        end
        for (int k = 31; k <= 45; k++) pushExp(e0 + k, 15, 1'b0, 1'b1, 1'b1);
        waitUntilEdge(e0 + 45);

        // Full ramp down from ON.
        $display("[TB] ramp down");
        applyStimulus(1'b0, e0);
        pushExp(e0, 15, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            pushExp(e0 + 2*k - 1, 16 - k, 1'b1, 1'b0, 1'b0);
            pushExp(e0 + 2*k, 15 - k, (k < 15), 1'b0, 1'b0);
        end
        for (int k = 31; k <= 45; k++) pushExp(e0 + k, 0, 1'b0, 1'b0, 1'b1);
        waitUntilEdge(e0 + 45);

        // Reverse at level 7 on a non-tick edge.
        $display("[TB] reverse at 7");
        applyStimulus(1'b1, e0);
        pushExp(e0, 0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            pushExp(e0 + 2*k - 1, k - 1, 1'b1, 1'b0, 1'b0);
            pushExp(e0 + 2*k, k, 1'b1, 1'b0, 1'b0);
        end
        waitUntilEdge(e0 + 13);
        applyStimulus(1'b0, r);
        checkOutput("reverse_edge_idx", r, e0 + 15);
        pushExp(r, 7, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            pushExp(r + 2*k - 1, 8 - k, 1'b1, 1'b0, 1'b0);
            pushExp(r + 2*k, 7 - k, (k < 7), 1'b0, 1'b0);
        end
        waitUntilEdge(r + 16);

        // Reverse on an edge where a step tick would land: level holds at 4.
        $display("[TB] reverse on tick");
        applyStimulus(1'b1, e0);
        pushExp(e0, 0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            pushExp(e0 + 2*k - 1, k - 1, 1'b1, 1'b0, 1'b0);
            pushExp(e0 + 2*k, k, 1'b1, 1'b0, 1'b0);
        end
        pushExp(e0 + 9, 4, 1'b1, 1'b0, 1'b0);
        waitUntilEdge(e0 + 8);
        applyStimulus(1'b0, r);
        pushExp(r, 4, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            pushExp(r + 2*k - 1, 5 - k, 1'b1, 1'b0, 1'b0);
            pushExp(r + 2*k, 4 - k, (k < 4), 1'b0, 1'b0);
        end
        waitUntilEdge(r + 10);

        // Asynchronous reset mid-ramp at level 9, then restart.
        $display("[TB] reset mid-ramp");
        applyStimulus(1'b1, e0);
        for (int k = 0; k <= 17; k++) pushExp(e0 + k, k / 2, 1'b1, 1'b0, 1'b0);
        waitUntilEdge(e0 + 18);
        checkOutput("pre_reset_level", int'(bus.level_o), 9);
        #2 rst_n = 1'b0;
        #1;
        checkNow("async_reset", 0, 0, 0);
        repeat (2) @(posedge clk);
        checkNow("held_reset", 0, 0, 0);
        #3 rst_n = 1'b1;
        e0 = edgeCnt + 1;
        pushExp(e0, 0, 1'b1, 1'b0, 1'b0);
        pushExp(e0 + 1, 0, 1'b1, 1'b0, 1'b0);
        pushExp(e0 + 2, 1, 1'b1, 1'b0, 1'b0);
        pushExp(e0 + 3, 1, 1'b1, 1'b0, 1'b0);
        pushExp(e0 + 4, 2, 1'b1, 1'b0, 1'b0);
        waitUntilEdge(e0 + 5);

        // Duty check on the slow instance: level 5 holds for 64 cycles.
        $display("[TB] duty at level 5");
        bus2.led_i = 1'b1;
        guard = 0;
        while (bus2.level_o != 4'd5 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("duty_reach_level", int'(bus2.level_o), 5);
        @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            highs = 0;
            for (int c = 0; c < 15; c++) begin
                @(posedge clk);
                #1;
                highs += int'(bus2.led_o);
            end
            checkOutput($sformatf("duty_window%0d", w), highs, 5);
        end
        checkOutput("duty_level_still", int'(bus2.level_o), 5);

        guard = 0;
        while (expQ.size() > 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        checkOutput("queue_drained", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
